// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory with a valid/ready request port and a registered load result.
// Optional macro DMEM_SUBWORD_EN enables byte/half accesses; otherwise only word accesses are legal.
module data_mem_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        rsp_valid,
  output logic        Err
);

  // state  | meaning
  // S_IDLE | ready for a request; accepted fields are captured here
  // S_WAIT | counting wait states down to terminal count
  // S_RESP | one-cycle response; access committed on the edge entering it
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                ld_q, ld_d;
  logic [1:0]          size_q, size_d;
  logic                sext_q, sext_d;
  logic [1:0]          off_q, off_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                commit;

  logic [31:0]         mem_q [2**ADDR_W];

  logic                req_err;
  logic                acc_ld;
  logic [1:0]          acc_size;
  logic                acc_sext;
  logic [1:0]          acc_off;
  logic [ADDR_W-1:0]   acc_idx;
  logic [31:0]         acc_wdata;
  logic [31:0]         mem_rd_word;
  logic [3:0]          be;
  logic [31:0]         wword;
  logic [31:0]         ld_val;

  always_comb begin
    req_err = (MemRead == MemWrite) || (Size == 2'b11) || (Addr[31:ADDR_W+2] != '0);
`ifdef DMEM_SUBWORD_EN
    if ((Size == 2'b01 && Addr[0]) || (Size == 2'b10 && Addr[1:0] != 2'b00))
      req_err = 1'b1;
`else
    if (Size != 2'b10 || Addr[1:0] != 2'b00)
      req_err = 1'b1;
`endif
  end

  // With zero wait states the commit happens on the accepting edge, so the
  // access fields come straight from the request port instead of the capture regs.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_ld    = MemRead;
      acc_size  = Size;
      acc_sext  = SignExt;
      acc_off   = Addr[1:0];
      acc_idx   = Addr[ADDR_W+1:2];
      acc_wdata = WriteData;
    end else begin
      acc_ld    = ld_q;
      acc_size  = size_q;
      acc_sext  = sext_q;
      acc_off   = off_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
    end
  end

  assign mem_rd_word = mem_q[acc_idx];

`ifdef DMEM_SUBWORD_EN
  logic [15:0] lane_sh;

  always_comb begin
    lane_sh = 16'(mem_rd_word >> {acc_off, 3'b000});
    be      = 4'hF;
    wword   = acc_wdata;
    ld_val  = mem_rd_word;
    case (acc_size)
      2'b00: begin
        be     = 4'b0001 << acc_off;
        wword  = {4{acc_wdata[7:0]}};
        ld_val = {{24{acc_sext & lane_sh[7]}}, lane_sh[7:0]};
      end
      2'b01: begin
        be     = acc_off[1] ? 4'b1100 : 4'b0011;
        wword  = {2{acc_wdata[15:0]}};
        ld_val = {{16{acc_sext & lane_sh[15]}}, lane_sh[15:0]};
      end
      default: begin
        be     = 4'hF;
        wword  = acc_wdata;
        ld_val = mem_rd_word;
      end
    endcase
  end
`else
  logic unused_subword;

  assign unused_subword = ^{acc_sext, acc_off, acc_size};
  assign be     = 4'hF;
  assign wword  = acc_wdata;
  assign ld_val = mem_rd_word;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    size_d  = size_q;
    sext_d  = sext_q;
    off_d   = off_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          ld_d    = MemRead;
          size_d  = Size;
          sext_d  = SignExt;
          off_d   = Addr[1:0];
          idx_d   = Addr[ADDR_W+1:2];
          wdata_d = WriteData;
          err_d   = req_err;
          if (req_err) begin
            state_d = S_RESP;
          end else if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (commit && acc_ld)
      rdata_d = ld_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ld_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      off_q   <= 2'b00;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      off_q   <= off_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is not reset; rst_n gating keeps a store from landing during reset.
  always_ff @(posedge clk) begin
    if (commit && !acc_ld && rst_n) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem_q[acc_idx][8*i +: 8] <= wword[8*i +: 8];
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign Err       = (state_q == S_RESP) && err_q;
  assign ReadData  = rdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed plan steps plus random traffic
// against a byte-addressed reference memory; follows DMEM_SUBWORD_EN like the DUT.
module tb_data_mem_ctrl;
  localparam int AW = 8;
  localparam int WC = 2;
  localparam int NBYTES = 4 << AW;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  Size;
  logic        SignExt;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        rsp_valid;
  logic        Err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  ref_mem [NBYTES];
  logic [31:0] ref_rd;

  data_mem_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .Size(Size), .SignExt(SignExt),
    .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
    .rsp_valid(rsp_valid), .Err(Err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_is_err(input bit rd, input bit wr, input logic [1:0] size,
                                    input logic [31:0] addr);
    int nb;
    if (rd == wr) return 1'b1;
    if (size == 2'd3) return 1'b1;
`ifndef DMEM_SUBWORD_EN
    if (size != 2'd2) return 1'b1;
`endif
    nb = 1 << size;
    if ((addr % nb) != 0) return 1'b1;
    if (addr >= NBYTES) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_req(input string tag, input bit rd, input bit wr, input logic [1:0] size,
                        input bit sext, input logic [31:0] addr, input logic [31:0] wdata);
    bit          e;
    int          lat;
    int          nb;
    logic [31:0] new_rd;
    e = ref_is_err(rd, wr, size, addr);
    new_rd = ref_rd;
    if (!e) begin
      nb = 1 << size;
      if (wr) begin
        for (int i = 0; i < nb; i++) ref_mem[addr + i] = wdata[8*i +: 8];
      end else begin
        new_rd = 32'h0;
        for (int i = 0; i < nb; i++) new_rd[8*i +: 8] = ref_mem[addr + i];
        if (sext && nb < 4 && new_rd[8*nb-1])
          for (int j = 8*nb; j < 32; j++) new_rd[j] = 1'b1;
      end
    end
    lat = e ? 1 : WC + 1;
    chk({tag, ":ready_before"}, {31'b0, req_ready}, 32'd1);
    MemRead = rd; MemWrite = wr; Size = size; SignExt = sext; Addr = addr; WriteData = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    MemRead = 1'($urandom); MemWrite = 1'($urandom); Size = 2'($urandom);
    SignExt = 1'($urandom); Addr = $urandom; WriteData = $urandom;
    for (int k = 1; k <= lat; k++) begin
      chk({tag, ":ready"}, {31'b0, req_ready}, 32'd0);
      chk({tag, ":rsp_valid"}, {31'b0, rsp_valid}, {31'b0, k == lat});
      chk({tag, ":err"}, {31'b0, Err}, {31'b0, (k == lat) && e});
      chk({tag, ":rdata"}, ReadData, (k == lat) ? new_rd : ref_rd);
      @(negedge clk);
    end
    ref_rd = new_rd;
    chk({tag, ":ready_after"}, {31'b0, req_ready}, 32'd1);
    chk({tag, ":rsp_after"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, ":err_after"}, {31'b0, Err}, 32'd0);
  endtask

  initial begin
    bit          rd, wr;
    logic [1:0]  sz;
    logic [31:0] ad;
    int          r;

    rst_n = 1'b0; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    Size = 2'b00; SignExt = 1'b0; Addr = 32'h0; WriteData = 32'h0;
    ref_rd = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset:ready", {31'b0, req_ready}, 32'd1);
    chk("reset:rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset:err", {31'b0, Err}, 32'd0);
    chk("reset:rdata", ReadData, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int w = 0; w < 16; w++) do_req("init", 1'b0, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom);

    do_req("st_word", 1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678);
    do_req("ld_word", 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    do_req("st_byte", 1'b0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB);
    do_req("ld_word2", 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    do_req("ld_byte_s", 1'b1, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
    do_req("ld_byte_z", 1'b1, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
    do_req("ld_half_s", 1'b1, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    do_req("ld_half_hi", 1'b1, 1'b0, 2'd1, 1'b1, 32'h0E, 32'h0);
    do_req("err_misal", 1'b1, 1'b0, 2'd2, 1'b0, 32'h12, 32'h0);
    do_req("err_range", 1'b0, 1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFEF00D);
    do_req("ld_zero", 1'b1, 1'b0, 2'd2, 1'b0, 32'h000, 32'h0);
    do_req("err_rdwr", 1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0);
    do_req("err_none", 1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    do_req("err_size3", 1'b1, 1'b0, 2'd3, 1'b0, 32'h10, 32'h0);

    do_req("st_pre", 1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11111111);
    MemRead = 1'b0; MemWrite = 1'b1; Size = 2'd2; SignExt = 1'b0;
    Addr = 32'h20; WriteData = 32'hDEADBEEF; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    ref_rd = 32'h0;
    chk("abort:rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("abort:ready", {31'b0, req_ready}, 32'd1);
    chk("abort:rdata", ReadData, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort:no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_req("abort:ld", 1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 15);
      if (r == 0) begin rd = 1'b1; wr = 1'b1; end
      else if (r == 1) begin rd = 1'b0; wr = 1'b0; end
      else begin rd = r[0]; wr = ~r[0]; end
      sz = ($urandom_range(0, 7) < 4) ? 2'd2 : 2'($urandom_range(0, 3));
      ad = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 63));
      if (sz == 2'd2 && $urandom_range(0, 3) != 0) ad[1:0] = 2'b00;
      do_req("rand", rd, wr, sz, 1'($urandom), ad, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
